// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for an RV32 subset (R-type, LW, SW, BEQ).
// Sequences a shared-ALU, shared-memory datapath and counts retired instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    input  logic             zero_i,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             ir_write_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [3:0]       state_o,
    output logic             halted_o,
    output logic [1:0]       cause_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] C_NONE    = 2'b00;
    localparam logic [1:0] C_ILLEGAL = 2'b01;
    localparam logic [1:0] C_TIMEOUT = 2'b10;

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit TO_EN = (MEM_TIMEOUT != 0);
    localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WC_W-1:0] TO_LAST = WC_W'(TO_LAST_I);

    state_t          state;
    state_t          state_nx;
    logic [1:0]      cause_nx;
    logic [WC_W-1:0] wait_cnt;
    logic            waiting;
    logic            timeout;
    logic            retire;

    assign waiting = (state == S_FETCH)
                  || (state == S_MEM_READ)
                  || (state == S_MEM_WRITE);

    // The last allowed not-ready cycle expires; a ready on it wins.
    assign timeout = TO_EN && waiting && !mem_ready_i
                  && (wait_cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        cause_nx = cause_o;
        retire   = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_HALT;
                    cause_nx = C_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_R:    state_nx = S_EXEC_R;
                    OP_LW:   state_nx = S_MEM_ADDR;
                    OP_SW:   state_nx = S_MEM_ADDR;
                    OP_BEQ:  state_nx = S_BRANCH;
                    default: begin
                        state_nx = S_HALT;
                        cause_nx = C_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                state_nx = (opcode_i == OP_SW) ? S_MEM_WRITE
                                               : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready_i) begin
                    state_nx = S_MEM_WB;
                end else if (timeout) begin
                    state_nx = S_HALT;
                    cause_nx = C_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                if (mem_ready_i) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end else if (timeout) begin
                    state_nx = S_HALT;
                    cause_nx = C_TIMEOUT;
                end
            end
            S_EXEC_R: state_nx = S_R_WB;
            S_R_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            S_HALT:  state_nx = S_HALT;
            default: begin
                state_nx = S_HALT;
                cause_nx = C_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            cause_o   <= C_NONE;
            retired_o <= '0;
        end else begin
            state     <= state_nx;
            cause_o   <= cause_nx;
            retired_o <= retired_o + CNT_W'(retire);
            // Any state change or completed access restarts the wait window.
            if (mem_ready_i || (state_nx != state)) begin
                wait_cnt <= '0;
            end else if (waiting && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        ir_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        if (!rst_i) begin
            unique case (state)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'b10;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b10;
                end
                S_R_WB: begin
                    reg_write_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b01;
                    pc_src_o    = 1'b1;
                    pc_write_o  = zero_i;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o  = state;
    assign halted_o = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: vector table plus
// hand-written timeout, halt and async-reset sequences.
module tb_multicycle_control;

    localparam int CNT_W = 2;

    // {pc_write,pc_src,ir_write,i_or_d,mem_read,mem_write,
    //  reg_write,mem_to_reg,src_a,src_b[1:0],alu_op[1:0]}
    localparam logic [12:0] K_NONE  = 13'b0000000000000;
    localparam logic [12:0] K_F_RDY = 13'b1010100000100;
    localparam logic [12:0] K_F_NR  = 13'b0000100000100;
    localparam logic [12:0] K_DEC   = 13'b0000000001000;
    localparam logic [12:0] K_MADDR = 13'b0000000011000;
    localparam logic [12:0] K_MRD   = 13'b0001100000000;
    localparam logic [12:0] K_MWB   = 13'b0000001100000;
    localparam logic [12:0] K_MWR   = 13'b0001010000000;
    localparam logic [12:0] K_EXR   = 13'b0000000010010;
    localparam logic [12:0] K_RWB   = 13'b0000001000000;
    localparam logic [12:0] K_BR_Z1 = 13'b1100000010001;
    localparam logic [12:0] K_BR_Z0 = 13'b0100000010001;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [6:0]       opcode_i;
    logic             mem_ready_i;
    logic             zero_i;
    logic             pc_write_o;
    logic             pc_src_o;
    logic             ir_write_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             reg_write_o;
    logic             mem_to_reg_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [3:0]       state_o;
    logic             halted_o;
    logic [1:0]       cause_o;
    logic [CNT_W-1:0] retired_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .opcode_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .zero_i      (zero_i),
        .pc_write_o  (pc_write_o),
        .pc_src_o    (pc_src_o),
        .ir_write_o  (ir_write_o),
        .i_or_d_o    (i_or_d_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .reg_write_o (reg_write_o),
        .mem_to_reg_o(mem_to_reg_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .state_o     (state_o),
        .halted_o    (halted_o),
        .cause_o     (cause_o),
        .retired_o   (retired_o)
    );

    logic [12:0] strb;
    assign strb = {pc_write_o, pc_src_o, ir_write_o, i_or_d_o,
                   mem_read_o, mem_write_o, reg_write_o,
                   mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                   alu_op_o};

    typedef struct {
        logic             rst;
        logic [6:0]       op;
        logic             rdy;
        logic             zero;
        logic [3:0]       st;
        logic [12:0]      strb;
        logic             halt;
        logic [1:0]       cause;
        logic [CNT_W-1:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [6:0] op,
        input logic rdy, input logic zero,
        input logic [3:0] st, input logic [12:0] s,
        input logic halt, input logic [1:0] cause,
        input logic [CNT_W-1:0] ret);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.zero = zero;
        v.st = st; v.strb = s; v.halt = halt;
        v.cause = cause; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [6:0] op,
                         input logic rdy, input logic zero);
        rst_i       = rst;
        opcode_i    = op;
        mem_ready_i = rdy;
        zero_i      = zero;
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " state"}, 32'(state_o), 32'(v.st));
        chk({tag, " strobes"}, 32'(strb), 32'(v.strb));
        chk({tag, " status"}, 32'({halted_o, cause_o, retired_o}),
            32'({v.halt, v.cause, v.ret}));
    endtask

    task automatic do_reset();
        drive(1'b1, 7'h00, 1'b0, 1'b0);
        next_cyc();
    endtask

    initial begin
        // Reset, then R, LW (2 wait cycles), SW, BEQ taken/not, illegal
        tbl.push_back(mk(1, 7'h33, 1, 0, 0, K_NONE,  0, 0, 0));
        tbl.push_back(mk(0, 7'h33, 1, 0, 0, K_F_RDY, 0, 0, 0));
        tbl.push_back(mk(0, 7'h33, 1, 0, 1, K_DEC,   0, 0, 0));
        tbl.push_back(mk(0, 7'h33, 1, 0, 6, K_EXR,   0, 0, 0));
        tbl.push_back(mk(0, 7'h33, 1, 0, 7, K_RWB,   0, 0, 0));
        tbl.push_back(mk(0, 7'h03, 1, 0, 0, K_F_RDY, 0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 0, 0, 1, K_DEC,   0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 0, 0, 2, K_MADDR, 0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 0, 0, 3, K_MRD,   0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 0, 0, 3, K_MRD,   0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 1, 0, 3, K_MRD,   0, 0, 1));
        tbl.push_back(mk(0, 7'h03, 0, 0, 4, K_MWB,   0, 0, 1));
        tbl.push_back(mk(0, 7'h23, 1, 0, 0, K_F_RDY, 0, 0, 2));
        tbl.push_back(mk(0, 7'h23, 1, 0, 1, K_DEC,   0, 0, 2));
        tbl.push_back(mk(0, 7'h23, 1, 0, 2, K_MADDR, 0, 0, 2));
        tbl.push_back(mk(0, 7'h23, 0, 0, 5, K_MWR,   0, 0, 2));
        tbl.push_back(mk(0, 7'h23, 1, 0, 5, K_MWR,   0, 0, 2));
        tbl.push_back(mk(0, 7'h63, 1, 1, 0, K_F_RDY, 0, 0, 3));
        tbl.push_back(mk(0, 7'h63, 1, 1, 1, K_DEC,   0, 0, 3));
        tbl.push_back(mk(0, 7'h63, 1, 1, 8, K_BR_Z1, 0, 0, 3));
        tbl.push_back(mk(0, 7'h63, 1, 0, 0, K_F_RDY, 0, 0, 0));
        tbl.push_back(mk(0, 7'h63, 1, 0, 1, K_DEC,   0, 0, 0));
        tbl.push_back(mk(0, 7'h63, 1, 0, 8, K_BR_Z0, 0, 0, 0));
        tbl.push_back(mk(0, 7'h13, 1, 0, 0, K_F_RDY, 0, 0, 1));
        tbl.push_back(mk(0, 7'h13, 1, 0, 1, K_DEC,   0, 0, 1));
        tbl.push_back(mk(0, 7'h13, 1, 0, 9, K_NONE,  1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].zero);
            chk_all($sformatf("vec%0d", i), tbl[i]);
            next_cyc();
        end

        // HALT is sticky for 20 cycles whatever the inputs do
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 7'h33, 1'(i % 2), 1'(i % 3 == 0));
            chk($sformatf("halt%0d", i),
                32'({state_o, halted_o, cause_o, retired_o, strb}),
                32'({4'd9, 1'b1, 2'b01, 2'd1, K_NONE}));
            next_cyc();
        end

        // Fetch timeout after exactly 4 not-ready cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'h33, 1'b0, 1'b0);
            chk($sformatf("fto_wait%0d", i),
                32'({state_o, strb}), 32'({4'd0, K_F_NR}));
            next_cyc();
        end
        drive(1'b0, 7'h33, 1'b1, 1'b0);
        chk("fto_halt", 32'({state_o, halted_o, cause_o, retired_o}),
            32'({4'd9, 1'b1, 2'b10, 2'd0}));
        next_cyc();

        // Ready on the 4th cycle wins, then LW with 3 waits in MEM_READ
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7'h03, 1'b0, 1'b0);
            next_cyc();
        end
        drive(1'b0, 7'h03, 1'b1, 1'b0);
        chk("fto_last_rdy", 32'({state_o, strb}), 32'({4'd0, K_F_RDY}));
        next_cyc();
        drive(1'b0, 7'h03, 1'b0, 1'b0);
        chk("fto_to_dec", 32'({state_o, cause_o}), 32'({4'd1, 2'b00}));
        next_cyc();
        drive(1'b0, 7'h03, 1'b0, 1'b0);
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7'h03, 1'b0, 1'b0);
            chk($sformatf("mrd_wait%0d", i),
                32'({state_o, strb}), 32'({4'd3, K_MRD}));
            next_cyc();
        end
        drive(1'b0, 7'h03, 1'b1, 1'b0);
        next_cyc();
        drive(1'b0, 7'h23, 1'b1, 1'b0);
        chk("mrd_wb", 32'({state_o, strb, halted_o}),
            32'({4'd4, K_MWB, 1'b0}));
        next_cyc();

        // SW with ready stuck low: timeout, no retire
        drive(1'b0, 7'h23, 1'b1, 1'b0);
        chk("sw_ret_before", 32'(retired_o), 32'd1);
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 7'h23, 1'b0, 1'b0);
            next_cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'h23, 1'b0, 1'b0);
            chk($sformatf("mwr_wait%0d", i), 32'(state_o), 32'd5);
            next_cyc();
        end
        drive(1'b0, 7'h23, 1'b1, 1'b0);
        chk("mwr_timeout", 32'({state_o, cause_o, retired_o}),
            32'({4'd9, 2'b10, 2'd1}));
        next_cyc();

        // R-type retires, then async reset in the middle of MEM_WRITE
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'h33, 1'b1, 1'b0);
            next_cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7'h23, 1'b1, 1'b0);
            next_cyc();
        end
        drive(1'b0, 7'h23, 1'b0, 1'b0);
        chk("arst_pre", 32'({state_o, strb, retired_o}),
            32'({4'd5, K_MWR, 2'd1}));
        #1 rst_i = 1'b1;
        #1;
        chk("arst_now", 32'({state_o, strb, halted_o, cause_o, retired_o}),
            32'({4'd0, K_NONE, 1'b0, 2'b00, 2'd0}));
        next_cyc();
        drive(1'b0, 7'h33, 1'b1, 1'b0);
        chk("arst_after", 32'({state_o, strb}), 32'({4'd0, K_F_RDY}));
        next_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
